// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode slot, forwarding sources,
// pipeline control and registered EX-side outputs.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int CNT_WIDTH      = 16
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rdata1;
  logic [DATA_WIDTH-1:0]     id_rdata2;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_use_imm;
  logic [SEL_WIDTH-1:0]      id_alu_sel;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      mem_valid;
  logic                      mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      wb_valid;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      hold;
  logic                      flush;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_input0;
  logic [DATA_WIDTH-1:0]     ex_input1;
  logic [SEL_WIDTH-1:0]      ex_alu_sel;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      stall;
  logic [CNT_WIDTH-1:0]      bubble_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_rdata1, id_rdata2, id_imm,
    output id_use_imm, id_alu_sel,
    output id_reg_write, id_mem_read,
    output alu_result,
    output mem_valid, mem_reg_write, mem_rd, mem_data,
    output wb_valid, wb_reg_write, wb_rd, wb_data,
    output hold, flush,
    input  ex_valid, ex_input0, ex_input1,
    input  ex_alu_sel, ex_rd,
    input  ex_reg_write, ex_mem_read,
    input  stall, bubble_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_rdata1, id_rdata2, id_imm,
    input  id_use_imm, id_alu_sel,
    input  id_reg_write, id_mem_read,
    input  alu_result,
    input  mem_valid, mem_reg_write, mem_rd, mem_data,
    input  wb_valid, wb_reg_write, wb_rd, wb_data,
    input  hold, flush,
    output ex_valid, ex_input0, ex_input1,
    output ex_alu_sel, ex_rd,
    output ex_reg_write, ex_mem_read,
    output stall, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM/WB forwarding,
// load-use bubble insertion, hold and flush.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  typedef enum logic {RUN, BUBBLE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q;
  state_t                state_d;
  logic                  stall_c;
  logic                  load_bubble;
  logic                  capture;
  logic                  ex_fw;
  logic                  mem_fw;
  logic                  wb_fw;
  logic                  hz_rs1;
  logic                  hz_rs2;
  logic                  hazard;
  logic [DATA_WIDTH-1:0] op0;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] in1;

  // a load in EX has no result yet, so it never forwards
  assign ex_fw  = bus.ex_valid & bus.ex_reg_write
                & ~bus.ex_mem_read;
  assign mem_fw = bus.mem_valid & bus.mem_reg_write;
  assign wb_fw  = bus.wb_valid & bus.wb_reg_write;

  always_comb begin
    op0 = bus.id_rdata1;
    if (bus.id_rs1 == '0)
      op0 = '0;
    else if (ex_fw && bus.ex_rd == bus.id_rs1)
      op0 = bus.alu_result;
    else if (mem_fw && bus.mem_rd == bus.id_rs1)
      op0 = bus.mem_data;
    else if (wb_fw && bus.wb_rd == bus.id_rs1)
      op0 = bus.wb_data;
  end

  always_comb begin
    op1 = bus.id_rdata2;
    if (bus.id_rs2 == '0)
      op1 = '0;
    else if (ex_fw && bus.ex_rd == bus.id_rs2)
      op1 = bus.alu_result;
    else if (mem_fw && bus.mem_rd == bus.id_rs2)
      op1 = bus.mem_data;
    else if (wb_fw && bus.wb_rd == bus.id_rs2)
      op1 = bus.wb_data;
  end

  assign in1 = bus.id_use_imm ? bus.id_imm : op1;

  assign hz_rs1 = bus.ex_rd == bus.id_rs1;
  assign hz_rs2 = ~bus.id_use_imm
                & (bus.ex_rd == bus.id_rs2);
  assign hazard = bus.id_valid & bus.ex_valid
                & bus.ex_mem_read
                & (bus.ex_rd != '0)
                & (hz_rs1 | hz_rs2);

  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    load_bubble = 1'b0;
    capture     = 1'b0;
    if (bus.flush) begin
      state_d = RUN;
    end else if (bus.hold) begin
      stall_c = 1'b1;
    end else if (state_q == RUN && hazard) begin
      stall_c     = 1'b1;
      load_bubble = 1'b1;
      state_d     = BUBBLE;
    end else begin
      capture = 1'b1;
      state_d = RUN;
    end
  end

  assign bus.stall = stall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_input0    <= '0;
      bus.ex_input1    <= '0;
      bus.ex_alu_sel   <= '0;
      bus.ex_rd        <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.bubble_count <= '0;
    end else if (bus.flush) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
    end else if (load_bubble) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      if (bus.bubble_count != CNT_MAX)
        bus.bubble_count <= bus.bubble_count
                          + CNT_WIDTH'(1);
    end else if (capture) begin
      bus.ex_valid     <= bus.id_valid;
      bus.ex_input0    <= op0;
      bus.ex_input1    <= in1;
      bus.ex_alu_sel   <= bus.id_alu_sel;
      bus.ex_rd        <= bus.id_rd;
      bus.ex_reg_write <= bus.id_reg_write;
      bus.ex_mem_read  <= bus.id_mem_read;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; a second instance
// with a 2-bit counter covers bubble_count saturation.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;

  id_ex_stage_if a ();
  id_ex_stage_if #(.CNT_WIDTH(2)) b ();

  id_ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  id_ex_stage #(.CNT_WIDTH(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  assign b.id_valid      = a.id_valid;
  assign b.id_rs1        = a.id_rs1;
  assign b.id_rs2        = a.id_rs2;
  assign b.id_rd         = a.id_rd;
  assign b.id_rdata1     = a.id_rdata1;
  assign b.id_rdata2     = a.id_rdata2;
  assign b.id_imm        = a.id_imm;
  assign b.id_use_imm    = a.id_use_imm;
  assign b.id_alu_sel    = a.id_alu_sel;
  assign b.id_reg_write  = a.id_reg_write;
  assign b.id_mem_read   = a.id_mem_read;
  assign b.alu_result    = a.alu_result;
  assign b.mem_valid     = a.mem_valid;
  assign b.mem_reg_write = a.mem_reg_write;
  assign b.mem_rd        = a.mem_rd;
  assign b.mem_data      = a.mem_data;
  assign b.wb_valid      = a.wb_valid;
  assign b.wb_reg_write  = a.wb_reg_write;
  assign b.wb_rd         = a.wb_rd;
  assign b.wb_data       = a.wb_data;
  assign b.hold          = a.hold;
  assign b.flush         = a.flush;

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       rw;
    logic       mr;
    logic       dc;
    logic [7:0] i0;
    logic [7:0] i1;
    logic [3:0] sel;
    logic [2:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt    = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  tag, got, exp);
  endtask

  function automatic exp_t mk(
    input logic v, input logic [7:0] i0,
    input logic [7:0] i1, input logic [3:0] sel,
    input logic [2:0] rd, input logic rw,
    input logic mr);
    exp_t e;
    e.v = v; e.i0 = i0; e.i1 = i1; e.sel = sel;
    e.rd = rd; e.rw = rw; e.mr = mr; e.dc = 1'b0;
    return e;
  endfunction

  function automatic exp_t nop();
    exp_t e;
    e = mk(1'b0, 8'h0, 8'h0, 4'h0, 3'h0, 1'b0, 1'b0);
    e.dc = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag);
    exp_t e;
    tick();
    e = sb.pop_front();
    check({tag, ".valid"}, a.ex_valid, e.v);
    check({tag, ".rw"}, a.ex_reg_write, e.rw);
    check({tag, ".mr"}, a.ex_mem_read, e.mr);
    check({tag, ".sat_valid"}, b.ex_valid, e.v);
    if (!e.dc) begin
      check({tag, ".in0"}, a.ex_input0, e.i0);
      check({tag, ".in1"}, a.ex_input1, e.i1);
      check({tag, ".sel"}, a.ex_alu_sel, e.sel);
      check({tag, ".rd"}, a.ex_rd, e.rd);
    end
  endtask

  task automatic id(
    input logic v, input logic [2:0] rs1,
    input logic [2:0] rs2, input logic [2:0] rd,
    input logic [7:0] d1, input logic [7:0] d2,
    input logic [7:0] imm, input logic ui,
    input logic [3:0] sel, input logic rw,
    input logic mr);
    a.id_valid = v;     a.id_rs1 = rs1;
    a.id_rs2 = rs2;     a.id_rd = rd;
    a.id_rdata1 = d1;   a.id_rdata2 = d2;
    a.id_imm = imm;     a.id_use_imm = ui;
    a.id_alu_sel = sel; a.id_reg_write = rw;
    a.id_mem_read = mr;
  endtask

  task automatic fw(
    input logic mv, input logic [2:0] mrd,
    input logic [7:0] md, input logic wv,
    input logic [2:0] wrd, input logic [7:0] wd);
    a.mem_valid = mv; a.mem_reg_write = mv;
    a.mem_rd = mrd;   a.mem_data = md;
    a.wb_valid = wv;  a.wb_reg_write = wv;
    a.wb_rd = wrd;    a.wb_data = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a.hold = 1'b0;
    a.flush = 1'b0;
    a.alu_result = 8'h00;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fw(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst.valid", a.ex_valid, 1'b0);
    check("rst.cnt", a.bubble_count, 16'd0);
    check("rst.stall", a.stall, 1'b0);
    check("rst.in0", a.ex_input0, 8'h00);
    rst = 1'b0;

    // EX forwarding and register 0
    id(1, 1, 0, 2, 8'h10, 0, 0, 0, 4'h0, 1, 0);
    sb.push_back(mk(1, 8'h10, 8'h00, 0, 2, 1, 0));
    tick_chk("ex_setup");
    a.alu_result = 8'h3C;
    id(1, 2, 0, 5, 8'h11, 0, 0, 0, 4'h0, 1, 0);
    sb.push_back(mk(1, 8'h3C, 8'h00, 0, 5, 1, 0));
    tick_chk("ex_fwd");
    id(1, 0, 0, 5, 8'h11, 0, 0, 0, 4'h0, 1, 0);
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 5, 1, 0));
    tick_chk("rs1_zero");

    // EX > MEM > WB priority
    id(1, 0, 0, 4, 0, 0, 0, 0, 4'h1, 1, 0);
    sb.push_back(mk(1, 8'h00, 8'h00, 1, 4, 1, 0));
    tick_chk("pri_setup");
    a.alu_result = 8'hA1;
    fw(1, 4, 8'hB2, 1, 4, 8'hC3);
    id(0, 0, 4, 4, 0, 8'h55, 0, 0, 4'h1, 1, 0);
    sb.push_back(mk(0, 8'h00, 8'hA1, 1, 4, 1, 0));
    tick_chk("pri_ex");
    sb.push_back(mk(0, 8'h00, 8'hB2, 1, 4, 1, 0));
    tick_chk("pri_mem");
    fw(0, 4, 8'hB2, 1, 4, 8'hC3);
    id(1, 0, 4, 4, 0, 8'h55, 0, 0, 4'h1, 1, 0);
    sb.push_back(mk(1, 8'h00, 8'hC3, 1, 4, 1, 0));
    tick_chk("pri_wb");
    fw(0, 0, 0, 0, 0, 0);

    // load-use on rs2, then immediate form
    id(1, 0, 0, 3, 0, 0, 0, 0, 4'h0, 1, 1);
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 3, 1, 1));
    tick_chk("load");
    id(1, 1, 3, 6, 8'h09, 8'h33, 0, 0, 4'h2, 1, 0);
    #1 check("lu_stall", a.stall, 1'b1);
    sb.push_back(nop());
    tick_chk("lu_bubble");
    cnt++;
    fw(1, 3, 8'h7E, 0, 0, 0);
    check("lu_stall_clr", a.stall, 1'b0);
    sb.push_back(mk(1, 8'h09, 8'h7E, 2, 6, 1, 0));
    tick_chk("lu_mem_fwd");
    check("lu_cnt", a.bubble_count, 16'd1);
    fw(0, 0, 0, 0, 0, 0);
    id(1, 0, 0, 3, 0, 0, 0, 0, 4'h0, 1, 1);
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 3, 1, 1));
    tick_chk("load2");
    id(1, 1, 3, 6, 8'h09, 8'h33, 8'h05, 1, 4'h2, 1, 0);
    #1 check("imm_stall", a.stall, 1'b0);
    sb.push_back(mk(1, 8'h09, 8'h05, 2, 6, 1, 0));
    tick_chk("imm_cap");
    check("imm_cnt", a.bubble_count, 16'd1);

    // hold, then flush overriding hold
    id(1, 1, 2, 7, 8'h10, 8'h20, 0, 0, 4'h0, 1, 0);
    sb.push_back(mk(1, 8'h10, 8'h20, 0, 7, 1, 0));
    tick_chk("add");
    a.hold = 1'b1;
    id(1, 1, 2, 5, 8'h99, 8'h99, 0, 0, 4'h3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", a.stall, 1'b1);
      sb.push_back(mk(1, 8'h10, 8'h20, 0, 7, 1, 0));
      tick_chk("hold");
    end
    a.flush = 1'b1;
    #1 check("flush_stall", a.stall, 1'b0);
    sb.push_back(nop());
    tick_chk("flush");
    a.hold = 1'b0;
    a.flush = 1'b0;
    check("flush_cnt", a.bubble_count, 16'd1);

    // more load-use hazards on rs1
    for (int k = 0; k < 4; k++) begin
      id(1, 0, 0, 3, 0, 0, 0, 0, 4'h0, 1, 1);
      sb.push_back(mk(1, 8'h00, 8'h00, 0, 3, 1, 1));
      tick_chk("sat_load");
      id(1, 3, 2, 6, 8'h33, 8'h44, 0, 0, 4'h2, 1, 0);
      #1 check("sat_stall", a.stall, 1'b1);
      sb.push_back(nop());
      tick_chk("sat_bubble");
      cnt++;
      fw(1, 3, 8'(8'h60 + k), 0, 0, 0);
      sb.push_back(mk(1, 8'(8'h60 + k), 8'h44,
                      2, 6, 1, 0));
      tick_chk("sat_cap");
      fw(0, 0, 0, 0, 0, 0);
      check("cnt", a.bubble_count, 16'(cnt));
      check("sat_cnt", b.bubble_count,
            (cnt > 3) ? 2'd3 : 2'(cnt));
    end

    // asynchronous reset mid-run
    check("pre_rst_valid", a.ex_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst.valid", a.ex_valid, 1'b0);
    check("mid_rst.in0", a.ex_input0, 8'h00);
    check("mid_rst.in1", a.ex_input1, 8'h00);
    check("mid_rst.sel", a.ex_alu_sel, 4'h0);
    check("mid_rst.rd", a.ex_rd, 3'h0);
    check("mid_rst.rw", a.ex_reg_write, 1'b0);
    check("mid_rst.cnt", a.bubble_count, 16'd0);
    check("mid_rst.sat_cnt", b.bubble_count, 2'd0);
    check("mid_rst.stall", a.stall, 1'b0);
    tick();
    rst = 1'b0;
    id(1, 1, 2, 1, 8'h21, 8'h42, 0, 0, 4'h5, 1, 0);
    sb.push_back(mk(1, 8'h21, 8'h42, 5, 1, 1, 0));
    tick_chk("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the execute-stage ALU; it produces the ALU's input0, input1 and select each cycle.
- Captures decoded operands and resolves data hazards by forwarding from EX, MEM and WB.
- Detects load-use hazards, stalls decode and inserts a bubble.
- Supports pipeline hold (downstream stall) and flush (branch redirect).

Parameters:
- DATA_WIDTH, 8, operand/result width; equals ALU input_width.
- SEL_WIDTH, 4, ALU select width; equals ALU select_size.
- REG_ADDR_WIDTH, 3, register index width; register 0 reads as zero.
- CNT_WIDTH, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a valid instruction.
- id_rs1, id_rs2  in  REG_ADDR_WIDTH each  source register indices.
- id_rd  in  REG_ADDR_WIDTH  destination register index.
- id_rdata1, id_rdata2  in  DATA_WIDTH each  register-file read data.
- id_imm  in  DATA_WIDTH  immediate value.
- id_use_imm  in  1  input1 takes id_imm instead of rs2.
- id_alu_sel  in  SEL_WIDTH  ALU operation select.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- alu_result  in  DATA_WIDTH  current ALU outputf, i.e. the result of the instruction in EX.
- mem_valid, mem_reg_write  in  1 each  MEM-stage instruction status.
- mem_rd  in  REG_ADDR_WIDTH  MEM-stage destination index.
- mem_data  in  DATA_WIDTH  MEM-stage result; this is the load data when the instruction is a load.
- wb_valid, wb_reg_write  in  1 each  WB-stage instruction status.
- wb_rd  in  REG_ADDR_WIDTH  WB-stage destination index.
- wb_data  in  DATA_WIDTH  WB-stage write data.
- hold  in  1  downstream stall; freezes this stage.
- flush  in  1  squash the instruction being captured or held.
- ex_valid  out  1  EX-stage valid.
- ex_input0, ex_input1  out  DATA_WIDTH each  registered ALU operands.
- ex_alu_sel  out  SEL_WIDTH  registered ALU select.
- ex_rd  out  REG_ADDR_WIDTH  registered destination index.
- ex_reg_write, ex_mem_read  out  1 each  registered control bits.
- stall  out  1  combinational; tells fetch/decode to hold the ID slot.
- bubble_count  out  CNT_WIDTH  number of load-use bubbles inserted; saturating.

Behaviour:
- Reset (asynchronous, immediate): every registered output is 0, bubble_count is 0, FSM is in RUN. stall is 0 because ex_valid is 0.
- Operand resolution (combinational, per source s = rs1 or rs2):
  - If s == 0, the operand is 0.
  - Otherwise priority is EX > MEM > WB > register file.
  - EX match: ex_valid & ex_reg_write & ~ex_mem_read & ex_rd == s; use alu_result.
  - MEM match: mem_valid & mem_reg_write & mem_rd == s; use mem_data.
  - WB match: wb_valid & wb_reg_write & wb_rd == s; use wb_data.
  - input1 = id_imm when id_use_imm; in that case rs2 forwarding and rs2 hazard detection are ignored.
- Load-use hazard: id_valid & ex_valid & ex_mem_read & ex_rd != 0, and ex_rd equals rs1, or equals rs2 when ~id_use_imm.
- FSM has two states:
  - RUN: on a hazard with ~hold & ~flush, assert stall. At the edge, load a bubble (ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0; data fields don't-care but held), increment bubble_count, and go to BUBBLE.
  - BUBBLE: stall is 0. The load is now in MEM, so the MEM forward supplies its data. Capture normally and return to RUN. A hazard cannot be re-detected here because ex_valid = 0.
- Capture (RUN with no hazard, or BUBBLE): all ex_* take the resolved ID values; ex_valid = id_valid. Latency from ID to EX outputs is 1 cycle.
- hold = 1:
  - All ex_* registers, FSM state and bubble_count are unchanged.
  - stall = 1 so decode also freezes.
  - Forwarded values are not re-evaluated.
- flush = 1:
  - Highest priority, above hold and hazard.
  - Next edge: ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0; FSM goes to RUN.
  - bubble_count is not incremented. stall is 0.
- Priority order: rst > flush > hold > load-use > capture.
- bubble_count saturates at 2^CNT_WIDTH - 1 and never wraps.
- All matches are gated by their stage's valid bit: an invalid stage never forwards and never triggers a hazard.

Test Plan:
- Reset mid-run: assert rst while ex_valid = 1 and bubble_count = 5 -> all outputs 0 immediately; after release, the next capture proceeds normally.
- EX forward: EX holds an ADD with rd = 2 and alu_result = 0x3C; ID has rs1 = 2, rdata1 = 0x11 -> ex_input0 = 0x3C one cycle later. Same case with rs1 = 0 -> ex_input0 = 0x00.
- Priority: EX, MEM and WB all target rd = 4 with data 0xA1, 0xB2, 0xC3 -> ex_input1 = 0xA1. With EX invalid -> 0xB2. With EX and MEM invalid -> 0xC3.
- Load-use: load with rd = 3 in EX; ID has rs2 = 3 and use_imm = 0 -> stall = 1 for exactly 1 cycle, ex_valid = 0 for 1 cycle, bubble_count goes 0 -> 1. Next capture takes mem_data = 0x7E as ex_input1. Repeat with use_imm = 1 and imm = 0x05 -> no stall, ex_input1 = 0x05.
- Hold then flush: capture an ADD (sel = 0, inputs 0x10, 0x20); hold for 3 cycles -> outputs unchanged and stall = 1. Then flush together with hold -> ex_valid = 0 on the next edge and stall = 0.
- Saturation: with CNT_WIDTH = 2, force 5 load-use hazards -> bubble_count reads 3 and stays at 3.
